// File: rtl/rv_regfile_multi.sv
// Parametrised register file with per-register busy scoreboard and a multi-cycle flush sweep.
// Latency: reads combinational (optional write bypass); writes and busy marks visible next cycle; flush takes NREGS cycles.
// Backpressure: ready is low during a flush, and writes, busy marks and clear requests are dropped while it is low.
module rv_regfile_multi #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   read_addr,
   output logic [NRD*XLEN-1:0] read_data,
   output logic [NRD-1:0]      read_busy,
   input  logic                write_enable,
   input  logic [AW-1:0]       write_addr,
   input  logic [XLEN-1:0]     write_data,
   input  logic                set_busy,
   input  logic [AW-1:0]       set_addr,
   input  logic                clear_req,
   output logic                ready
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic             idle;
   logic             wr_en;
   logic             set_en;

   assign idle   = (state_q == IDLE);
   assign ready  = idle;
   assign wr_en  = idle && write_enable && !((ZERO_REG != 0) && (write_addr == '0));
   assign set_en = idle && set_busy && !((ZERO_REG != 0) && (set_addr == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            // cnt wraps to zero naturally because NREGS is a power of two
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(NREGS - 1)) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         busy <= '0;
      end else if (!idle) begin
         regs[cnt_q] <= '0;
         busy[cnt_q] <= 1'b0;
      end else begin
         if (wr_en) begin
            regs[write_addr] <= write_data;
            busy[write_addr] <= 1'b0;
         end
         // a producer issued in the same cycle as a write to its register wins
         if (set_en) busy[set_addr] <= 1'b1;
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0] addr;
      logic          is_zero;
      logic          is_byp;

      assign addr    = read_addr[g*AW +: AW];
      assign is_zero = (ZERO_REG != 0) && (addr == '0);
      assign is_byp  = (BYPASS != 0) && idle && write_enable && (write_addr == addr);

      assign read_data[g*XLEN +: XLEN] = is_zero ? '0 : (is_byp ? write_data : regs[addr]);
      assign read_busy[g]              = !is_zero && !is_byp && busy[addr];
   end

endmodule

// File: tb/tb_rv_regfile_multi.sv
// Bench for rv_regfile_multi: a bypassing and a non-bypassing instance share stimulus.
module tb_rv_regfile_multi;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [AW-1:0]       ra0, ra1, wa, sa;
   logic [NRD*AW-1:0]   read_addr;
   logic [NRD*XLEN-1:0] rd_b, rd_n;
   logic [NRD-1:0]      rb_b, rb_n;
   logic                we, sb, clr, rdy_b, rdy_n;
   logic [XLEN-1:0]     wd;

   assign read_addr = {ra1, ra0};

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] m_regs [NREGS];
   logic            m_busy [NREGS];
   int              flush_left;

   rv_regfile_multi #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .read_addr(read_addr), .read_data(rd_b), .read_busy(rb_b),
      .write_enable(we), .write_addr(wa), .write_data(wd), .set_busy(sb), .set_addr(sa),
      .clear_req(clr), .ready(rdy_b));

   rv_regfile_multi #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .read_addr(read_addr), .read_data(rd_n), .read_busy(rb_n),
      .write_enable(we), .write_addr(wa), .write_data(wd), .set_busy(sb), .set_addr(sa),
      .clear_req(clr), .ready(rdy_n));

   function automatic void model_reset();
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      flush_left = 0;
   endfunction

   // Behaviour at one rising edge, using the inputs currently applied.
   function automatic void model_step();
      if (flush_left > 0) begin
         m_regs[NREGS - flush_left] = '0;
         m_busy[NREGS - flush_left] = 1'b0;
         flush_left--;
      end else begin
         if (we && wa != 0) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
         end
         if (sb && sa != 0) m_busy[sa] = 1'b1;
         if (clr) flush_left = NREGS;
      end
   endfunction

   function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return '0;
      if (byp && flush_left == 0 && we && wa == a) return wd;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return 1'b0;
      if (byp && flush_left == 0 && we && wa == a) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rst) model_step();
      #1;
   endtask

   task automatic idle_inputs();
      we = 1'b0; sb = 1'b0; clr = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      wa = '0; sa = '0; wd = '0; ra0 = '0; ra1 = '0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      we = 1'b1; wa = 5'd5; wd = 32'hAB; sb = 1'b1; sa = 5'd6;
      tick();
      idle_inputs();
      #3 rst = 1'b1;
      for (int i = 0; i < NREGS; i++) begin
         ra0 = AW'(i); ra1 = AW'(NREGS - 1 - i);
         #1;
         checks++;
         if (rd_b !== '0 || rd_n !== '0) begin
            errors++;
            $display("FAIL reset_data reg %0d got %h/%h want 0", i, rd_b, rd_n);
         end
         checks++;
         if (rb_b !== '0 || rb_n !== '0) begin
            errors++;
            $display("FAIL reset_busy reg %0d got %b/%b want 0", i, rb_b, rb_n);
         end
      end
      checks++;
      if (rdy_b !== 1'b1 || rdy_n !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b/%b want 1", rdy_b, rdy_n);
      end
      model_reset();
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_write_read();
      we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
      tick();
      idle_inputs();
      ra0 = 5'd5; ra1 = 5'd5;
      #1;
      checks++;
      if (rd_b !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL write_read_byp got %h want deadbeefdeadbeef", rd_b);
      end
      checks++;
      if (rd_n !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL write_read_nobyp got %h want deadbeefdeadbeef", rd_n);
      end
      we = 1'b1; wa = 5'd0; wd = 32'h1234; ra0 = 5'd0;
      #1;
      checks++;
      if (rd_b[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL x0_bypass got %h want 0", rd_b[31:0]);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (rd_b[31:0] !== 32'h0 || rd_n[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL x0_write got %h/%h want 0", rd_b[31:0], rd_n[31:0]);
      end
   endtask

   task automatic test_bypass();
      we = 1'b1; wa = 5'd7; wd = 32'h11;
      tick();
      we = 1'b0; sb = 1'b1; sa = 5'd7;
      tick();
      sb = 1'b0;
      we = 1'b1; wa = 5'd7; wd = 32'h22; ra0 = 5'd7;
      #1;
      checks++;
      if (rd_b[31:0] !== 32'h22 || rb_b[0] !== 1'b0) begin
         errors++;
         $display("FAIL bypass_on got %h busy %b want 22 busy 0", rd_b[31:0], rb_b[0]);
      end
      checks++;
      if (rd_n[31:0] !== 32'h11 || rb_n[0] !== 1'b1) begin
         errors++;
         $display("FAIL bypass_off got %h busy %b want 11 busy 1", rd_n[31:0], rb_n[0]);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (rd_n[31:0] !== 32'h22 || rb_n[0] !== 1'b0) begin
         errors++;
         $display("FAIL bypass_off_next got %h busy %b want 22 busy 0", rd_n[31:0], rb_n[0]);
      end
   endtask

   task automatic test_scoreboard();
      sb = 1'b1; sa = 5'd9; ra0 = 5'd9;
      tick();
      sb = 1'b0;
      #1;
      checks++;
      if (rb_b[0] !== 1'b1 || rb_n[0] !== 1'b1) begin
         errors++;
         $display("FAIL sb_set got %b/%b want 1", rb_b[0], rb_n[0]);
      end
      we = 1'b1; wa = 5'd9; wd = 32'h5;
      tick();
      idle_inputs();
      #1;
      checks++;
      if (rb_b[0] !== 1'b0 || rb_n[0] !== 1'b0) begin
         errors++;
         $display("FAIL sb_write_clears got %b/%b want 0", rb_b[0], rb_n[0]);
      end
      we = 1'b1; wa = 5'd9; wd = 32'h5; sb = 1'b1; sa = 5'd9;
      tick();
      idle_inputs();
      #1;
      checks++;
      if (rb_b[0] !== 1'b1 || rd_b[31:0] !== 32'h5) begin
         errors++;
         $display("FAIL sb_write_and_set got busy %b data %h want 1 5", rb_b[0], rd_b[31:0]);
      end
      sb = 1'b1; sa = 5'd0; ra0 = 5'd0;
      tick();
      sb = 1'b0;
      #1;
      checks++;
      if (rb_b[0] !== 1'b0 || rb_n[0] !== 1'b0) begin
         errors++;
         $display("FAIL sb_x0 got %b/%b want 0", rb_b[0], rb_n[0]);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      for (int it = 0; it < 600; it++) begin
         we  = 1'($urandom_range(0, 1));
         sb  = 1'($urandom_range(0, 1));
         wa  = AW'($urandom_range(0, NREGS - 1));
         sa  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREGS - 1));
         wd  = $urandom;
         ra0 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, NREGS - 1));
         ra1 = AW'($urandom_range(0, NREGS - 1));
         clr = ($urandom_range(0, 79) == 0);
         #1;
         for (int p = 0; p < NRD; p++) begin
            a = (p == 0) ? ra0 : ra1;
            checks++;
            if (rd_b[p*XLEN +: XLEN] !== exp_data(a, 1'b1)) begin
               errors++;
               $display("FAIL rand_data_byp it %0d port %0d addr %0d got %h want %h",
                        it, p, a, rd_b[p*XLEN +: XLEN], exp_data(a, 1'b1));
            end
            checks++;
            if (rd_n[p*XLEN +: XLEN] !== exp_data(a, 1'b0)) begin
               errors++;
               $display("FAIL rand_data_nobyp it %0d port %0d addr %0d got %h want %h",
                        it, p, a, rd_n[p*XLEN +: XLEN], exp_data(a, 1'b0));
            end
            checks++;
            if (rb_b[p] !== exp_busy(a, 1'b1) || rb_n[p] !== exp_busy(a, 1'b0)) begin
               errors++;
               $display("FAIL rand_busy it %0d port %0d addr %0d got %b/%b want %b/%b",
                        it, p, a, rb_b[p], rb_n[p], exp_busy(a, 1'b1), exp_busy(a, 1'b0));
            end
         end
         checks++;
         if (rdy_b !== (flush_left == 0) || rdy_n !== (flush_left == 0)) begin
            errors++;
            $display("FAIL rand_ready it %0d got %b/%b want %b", it, rdy_b, rdy_n, flush_left == 0);
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_flush();
      int n;
      for (int i = 0; i < 40 && flush_left > 0; i++) tick();
      for (int i = 1; i < NREGS; i++) begin
         we = 1'b1; wa = AW'(i); wd = XLEN'(i);
         tick();
      end
      we = 1'b0; sb = 1'b1; sa = 5'd3;
      tick();
      sb = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      n = 0;
      while (rdy_b === 1'b0 && n < 64) begin
         checks++;
         if (rdy_n !== 1'b0 || flush_left == 0) begin
            errors++;
            $display("FAIL flush_ready_low cycle %0d got %b want 0", n, rdy_n);
         end
         we = 1'($urandom_range(0, 1)); wa = AW'($urandom_range(1, NREGS - 1)); wd = $urandom;
         sb = 1'($urandom_range(0, 1)); sa = AW'($urandom_range(1, NREGS - 1));
         clr = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      idle_inputs();
      checks++;
      if (n != NREGS) begin
         errors++;
         $display("FAIL flush_len got %0d cycles want %0d", n, NREGS);
      end
      for (int i = 0; i < NREGS; i++) begin
         ra0 = AW'(i); ra1 = AW'(i);
         #1;
         checks++;
         if (rd_b !== '0 || rd_n !== '0 || rb_b !== '0 || rb_n !== '0) begin
            errors++;
            $display("FAIL flush_cleared reg %0d got %h/%h busy %b/%b want 0", i, rd_b, rd_n, rb_b, rb_n);
         end
      end
      checks++;
      if (rdy_b !== 1'b1 || rdy_n !== 1'b1) begin
         errors++;
         $display("FAIL flush_ready_after got %b/%b want 1", rdy_b, rdy_n);
      end
   endtask

   task automatic test_reset_midflush();
      we = 1'b1; wa = 5'd4; wd = 32'h77;
      tick();
      we = 1'b0; sb = 1'b1; sa = 5'd12;
      tick();
      sb = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (10) tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (rdy_b !== 1'b1 || rdy_n !== 1'b1) begin
         errors++;
         $display("FAIL midflush_ready got %b/%b want 1", rdy_b, rdy_n);
      end
      for (int i = 0; i < NREGS; i++) begin
         ra0 = AW'(i); ra1 = AW'(NREGS - 1 - i);
         #1;
         checks++;
         if (rd_b !== '0 || rd_n !== '0 || rb_b !== '0 || rb_n !== '0) begin
            errors++;
            $display("FAIL midflush_zero reg %0d got %h/%h busy %b/%b want 0", i, rd_b, rd_n, rb_b, rb_n);
         end
      end
      model_reset();
      @(negedge clk) rst = 1'b0;
      we = 1'b1; wa = 5'd4; wd = 32'hA5; ra0 = 5'd4;
      tick();
      idle_inputs();
      #1;
      checks++;
      if (rd_b[31:0] !== 32'hA5 || rd_n[31:0] !== 32'hA5) begin
         errors++;
         $display("FAIL midflush_write got %h/%h want a5", rd_b[31:0], rd_n[31:0]);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_random();
      test_flush();
      test_reset_midflush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_regfile_multi.md
# rv_regfile_multi

Parametrised successor to the RV32I register file for the pipelined core. It supports configurable data width, register count and number of read ports. A write-to-read bypass is optional, and the x0 hardwire is selectable. It adds a per-register busy scoreboard for hazard detection and a multi-cycle flush sequencer that zeroes the array without a global reset. It sits between decode (reads, busy marking) and writeback (writes).

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of registers (power of two, ≥2); AW = $clog2(NREGS)
- NRD, 2, number of read ports (≥1)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and busy marking
- BYPASS, 1, 1 = read of the register being written this cycle returns write_data

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- read_addr  input  NRD*AW  packed read addresses; port i at [i*AW +: AW]
- read_data  output  NRD*XLEN  packed read data; port i at [i*XLEN +: XLEN]
- read_busy  output  NRD  busy bit of each addressed register
- write_enable  input  1  write strobe
- write_addr  input  AW  write address
- write_data  input  XLEN  write data
- set_busy  input  1  mark set_addr busy (issue of a producer)
- set_addr  input  AW  register to mark busy
- clear_req  input  1  request array flush
- ready  output  1  1 = IDLE, accepting writes, sets and clear requests

## Operation
- State: array regs[NREGS], busy[NREGS], FSM {IDLE, CLEAR}, sweep counter cnt[AW].
- Reset (async, rst=1): all regs=0, busy=0, state=IDLE, cnt=0, ready=1.
- Read port i (combinational):
  - If ZERO_REG and addr==0: data=0, busy=0.
  - Else if BYPASS and state==IDLE and write_enable and write_addr==addr (and not the ZERO_REG x0 case): data=write_data, busy=0.
  - Else: data=regs[addr], busy=busy[addr].
- Write (IDLE only): on the clock edge, regs[write_addr]<=write_data and busy[write_addr]<=0. The write is ignored when write_addr==0 and ZERO_REG=1.
- Set busy (IDLE only): busy[set_addr]<=1. It is ignored when set_addr==0 and ZERO_REG=1.
- Write and set to the same address in one cycle: data is written and busy ends 1, because the new producer wins.
- Write and set to different addresses in one cycle: both take effect.
- IDLE→CLEAR: on clear_req in IDLE. A write or set in that same cycle still completes. cnt<=0.
- CLEAR, each cycle: regs[cnt]<=0 and busy[cnt]<=0, then cnt<=cnt+1.
  - When cnt==NREGS-1 the state returns to IDLE and cnt wraps to 0.
  - write_enable, set_busy and clear_req are ignored in CLEAR.
  - Reads return current array contents, which are partially cleared. Bypass is disabled.
- rst asserted mid-CLEAR: the array is zeroed immediately, state=IDLE, and the sweep is abandoned.

## Timing
- Read latency 0 cycles (combinational from address, and from write inputs when BYPASS=1).
- Write visible through the array on the cycle after the edge. With BYPASS=1 it is visible in the same cycle.
- busy visible the cycle after set_busy.
- ready = (state==IDLE), registered through the state, so it drops the cycle after clear_req is accepted.
- Flush takes exactly NREGS cycles in CLEAR, with ready=0 for NREGS cycles.

## Test plan
- Reset: assert rst asynchronously mid-cycle. All read_data=0, read_busy=0 and ready=1 immediately, before any clock edge.
- Write/read:
  - Write 0xDEADBEEF to x5, then read port 0 addr 5 and port 1 addr 5 next cycle: both 0xDEADBEEF.
  - Write 0x1234 to x0 (ZERO_REG=1), then read x0: returns 0.
- Bypass (BYPASS=1): x7 holds 0x11. In the same cycle, write 0x22 to x7 and read x7: returns 0x22 with busy=0. With BYPASS=0 the same cycle returns 0x11, and 0x22 appears next cycle.
- Scoreboard:
  - set_busy x9, then read_busy=1.
  - write x9 with 0x5, then read_busy=0 next cycle.
  - Write and set x9 in the same cycle, then read_busy=1 and data=0x5.
  - set_busy x0, then read_busy=0.
- Flush (NREGS=32):
  - Fill x1..x31 with their index and mark x3 busy, then pulse clear_req.
  - Required response: ready=0 for exactly 32 cycles, and writes/sets issued during the flush have no effect.
  - Afterwards all registers read 0, all busy=0, ready=1.
- Reset mid-flush: assert rst 10 cycles into CLEAR. Immediately all registers read 0, ready=1, and a subsequent write to x4 of 0xA5 reads back 0xA5.
